mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
- Shares one single-ported, word-wide data memory between the instruction-fetch requester and the load/store requester. The load/store requester is the control unit's memory path.
- Sequences every access as a multi-cycle transaction. Sub-word stores are done as read-modify-write; loads get lane extraction and sign/zero extension.
- Loads and stores have priority over fetch. A starvation counter guarantees fetch progress.
- Sits between the fetch/control logic and the memory macro; only one transaction is outstanding at a time.

Parameters:
- MEM_LAT, 1, cycles from mem_rd_en high to mem_rdata valid (legal range 1..4).
- STARVE_LIM, 4, consecutive lost arbitrations by fetch before fetch wins one arbitration (legal range 1..15).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request; held stable until if_gnt.
- if_addr  in  32  fetch address; bits [1:0] are ignored (word fetch).
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle fetch completion.
- if_rdata  out  32  fetched word; valid with if_rvalid.
- ls_req  in  1  load/store request; held stable until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- ls_unsigned  in  1  zero-extend load result (lbu/lhu).
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data, taken from the low bytes.
- ls_gnt  out  1  load/store accepted this cycle (combinational).
- ls_rvalid  out  1  one-cycle load/store completion.
- ls_rdata  out  32  extended load result; 0 for stores.
- ls_err  out  1  misaligned or illegal access; valid with ls_rvalid.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_rd_en  out  1  memory read strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word, valid MEM_LAT cycles after mem_rd_en.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - State returns to IDLE and the starvation counter clears to 0.
  - All outputs drive 0 from the next cycle.
  - A transaction in flight is aborted: no rvalid and no memory write are issued afterwards.
- States: IDLE, RD_ISSUE, RD_WAIT, MERGE_WR, WR_ISSUE, RESP, ERR_RESP.
- Arbitration happens only in IDLE; requests are ignored in every other state.
  - Only ls_req high: grant ls.
  - Only if_req high: grant if.
  - Both high: grant ls, unless the starvation counter equals STARVE_LIM, in which case grant if.
- Starvation counter:
  - Increments, saturating at STARVE_LIM, each time fetch is denied while if_req is high.
  - Clears whenever fetch is granted.
- The granted gnt is high for exactly the acceptance cycle T. Address, size, data and type are captured at the end of T.
- Alignment check at T: a load/store is misaligned when size 01 has addr[0] = 1, size 10 has addr[1:0] != 0, or size is 11.
  - Misaligned goes to ERR_RESP: ls_rvalid = 1 and ls_err = 1 at T+1, then IDLE. No memory strobe is issued.
- Fetch or load:
  - RD_ISSUE at T+1 with mem_rd_en = 1 and mem_addr = {addr[31:2], 2'b00}.
  - RD_WAIT runs a down-counter; mem_rdata is sampled at T+1+MEM_LAT.
  - RESP at T+2+MEM_LAT: rvalid = 1 and rdata is registered.
- Load extraction uses the lane selected by addr[1:0].
  - Byte: lane = byte addr[1:0]. Half: lane = addr[1] ? [31:16] : [15:0].
  - Sign-extend the lane unless ls_unsigned = 1, which zero-extends it.
  - Word: no extension.
- Word store: WR_ISSUE at T+1 with mem_wr_en = 1 and mem_wdata = ls_wdata. RESP at T+2 with ls_rvalid = 1.
- Byte/half store (read-modify-write):
  - Read as for a load; the word read is sampled at T+1+MEM_LAT.
  - MERGE_WR at T+2+MEM_LAT: mem_wr_en = 1 to the same address. Only the addressed lane is replaced by ls_wdata[7:0] or ls_wdata[15:0]; all other bytes are preserved.
  - RESP at T+3+MEM_LAT.
- RESP and ERR_RESP last one cycle and go to IDLE. Earliest next grant is the following cycle.
- mem_rd_en and mem_wr_en are never high together. Each is high for exactly one cycle per issue. mem_addr and mem_wdata are 0 whenever neither strobe is high.
- ls_rdata, if_rdata and ls_err are 0 whenever the corresponding rvalid is 0.

Test Plan:
- Reset hold: rst = 0 for 3 cycles with both requests high -> no gnt, all outputs 0, no memory strobes.
- Signed/unsigned byte load, MEM_LAT = 1: memory word 0x80FF0000, ls_addr = 0x103, lb granted at T -> mem_rd_en at T+1 with mem_addr 0x100; ls_rvalid at T+3 with ls_rdata = 0xFFFFFF80. The same access as lbu returns 0x00000080.
- Sub-word store RMW: memory word 0x11223344 at 0x200, sb to 0x201 with ls_wdata = 0xAB -> read at T+1, write at T+3 with mem_wdata = 0x1122AB44, ls_rvalid at T+4. sh to 0x202 with 0xBEEF -> mem_wdata = 0xBEEF3344.
- Misalignment: lw to 0x102, then lh to 0x101 -> ls_rvalid = 1 and ls_err = 1 at T+1, no mem_rd_en or mem_wr_en. ls_size = 11 gives the same result.
- Starvation with STARVE_LIM = 4: if_req and ls_req held high continuously -> ls wins 4 arbitrations, fetch wins the 5th, and the pattern repeats.
- Reset mid-RMW: rst = 0 at the cycle after the RMW read issue -> no mem_wr_en, no ls_rvalid, state IDLE after rst releases.

Source files
------------

// File: rtl/mem_port_sequencer_if.sv
// ============================================================================
// Module : mem_port_sequencer_if
// Brief  : Fetch, load/store and memory-macro signals of the port sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_port_sequencer_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Requesters and the memory macro.
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    // The sequencer itself.
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_sequencer.sv
// ============================================================================
// Module : mem_port_sequencer
// Brief  : Arbitrates fetch and load/store onto one single-ported data memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_port_sequencer #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_sequencer_if.slave bus
);
    localparam logic [1:0] c_wait_init  = 2'(MEM_LAT - 1);
    localparam logic [3:0] c_starve_lim = 4'(STARVE_LIM);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        MERGE_WR = 3'd3,
        WR_ISSUE = 3'd4,
        RESP     = 3'd5,
        ERR_RESP = 3'd6
    } state_t;

    state_t      r_state;
    logic [3:0]  r_starve;
    logic [1:0]  r_cnt;
    logic        r_is_fetch;
    logic        r_is_store;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [29:0] r_word_addr;
    logic [15:0] r_wdata;

    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_ls_rvalid;
    logic [31:0] r_ls_rdata;
    logic        r_ls_err;
    logic [31:0] r_mem_addr;
    logic        r_mem_rd_en;
    logic        r_mem_wr_en;
    logic [31:0] r_mem_wdata;

    logic        w_arb_idle;
    logic        w_starved;
    logic        w_ls_gnt;
    logic        w_if_gnt;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;
    wire         w_unused = ^bus.if_addr[1:0];

    // Grants are suppressed while reset is asserted so no request is accepted then.
    always_comb begin
        w_arb_idle   = (r_state == IDLE) && rst;
        w_starved    = (r_starve == c_starve_lim);
        w_ls_gnt     = w_arb_idle && bus.ls_req && !(bus.if_req && w_starved);
        w_if_gnt     = w_arb_idle && bus.if_req && !w_ls_gnt;
        w_misaligned = (bus.ls_size == 2'b11) ||
                       ((bus.ls_size == 2'b01) && bus.ls_addr[0]) ||
                       ((bus.ls_size == 2'b10) && (bus.ls_addr[1:0] != 2'b00));
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    // Read-modify-write: only the addressed lane changes, the rest of the word is kept.
    always_comb begin
        w_merge_data = bus.mem_rdata;
        if (r_size == 2'b00) begin
            w_merge_data[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge_data[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_starve    <= 4'd0;
            r_cnt       <= 2'd0;
            r_is_fetch  <= 1'b0;
            r_is_store  <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_lane      <= 2'b00;
            r_word_addr <= 30'd0;
            r_wdata     <= 16'h0000;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_ls_rvalid <= 1'b0;
            r_ls_rdata  <= 32'd0;
            r_ls_err    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_wdata <= 32'd0;
        end else begin
            // Every output is a single-cycle pulse; default to idle each cycle.
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_ls_rvalid <= 1'b0;
            r_ls_rdata  <= 32'd0;
            r_ls_err    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_wdata <= 32'd0;
            case (r_state)
                IDLE: begin
                    if (w_ls_gnt) begin
                        r_is_fetch  <= 1'b0;
                        r_is_store  <= bus.ls_we;
                        r_size      <= bus.ls_size;
                        r_unsigned  <= bus.ls_unsigned;
                        r_lane      <= bus.ls_addr[1:0];
                        r_word_addr <= bus.ls_addr[31:2];
                        r_wdata     <= bus.ls_wdata[15:0];
                        if (bus.if_req && !w_starved) begin
                            r_starve <= r_starve + 4'd1;
                        end
                        if (w_misaligned) begin
                            r_ls_rvalid <= 1'b1;
                            r_ls_err    <= 1'b1;
                            r_state     <= ERR_RESP;
                        end else if (bus.ls_we && (bus.ls_size == 2'b10)) begin
                            r_mem_wr_en <= 1'b1;
                            r_mem_addr  <= {bus.ls_addr[31:2], 2'b00};
                            r_mem_wdata <= bus.ls_wdata;
                            r_state     <= WR_ISSUE;
                        end else begin
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= {bus.ls_addr[31:2], 2'b00};
                            r_state     <= RD_ISSUE;
                        end
                    end else if (w_if_gnt) begin
                        r_starve    <= 4'd0;
                        r_is_fetch  <= 1'b1;
                        r_is_store  <= 1'b0;
                        r_word_addr <= bus.if_addr[31:2];
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= {bus.if_addr[31:2], 2'b00};
                        r_state     <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    r_cnt   <= c_wait_init;
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (r_is_fetch) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.mem_rdata;
                            r_state     <= RESP;
                        end else if (r_is_store) begin
                            r_mem_wr_en <= 1'b1;
                            r_mem_addr  <= {r_word_addr, 2'b00};
                            r_mem_wdata <= w_merge_data;
                            r_state     <= MERGE_WR;
                        end else begin
                            r_ls_rvalid <= 1'b1;
                            r_ls_rdata  <= w_load_data;
                            r_state     <= RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                MERGE_WR, WR_ISSUE: begin
                    r_ls_rvalid <= 1'b1;
                    r_state     <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.ls_gnt    = w_ls_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ls_rvalid = r_ls_rvalid;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.ls_err    = r_ls_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_rd_en = r_mem_rd_en;
    assign bus.mem_wr_en = r_mem_wr_en;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

`default_nettype wire

// File: tb/tb_mem_port_sequencer.sv
// ============================================================================
// Module : tb_mem_port_sequencer
// Brief  : Directed scoreboard bench for mem_port_sequencer with a 1-cycle memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_sequencer;
    localparam int c_mem_lat    = 1;
    localparam int c_starve_lim = 4;

    logic clk;
    logic rst;
    mem_port_sequencer_if bus ();

    mem_port_sequencer #(.MEM_LAT(c_mem_lat), .STARVE_LIM(c_starve_lim)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic err; int due; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int due; } wr_t;

    rsp_t ls_q[$];
    rsp_t if_q[$];
    wr_t  wr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rv_cnt = 0;
    bit mon_en = 1'b0;

    logic        pre_en   = 1'b0;
    logic [31:0] pre_addr = 32'd0;
    logic [31:0] pre_data = 32'd0;
    logic [31:0] mem [0:255];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Memory macro model: read data is valid in the cycle after the read strobe.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr[9:2]] = pre_data;
        if (bus.mem_rd_en === 1'b1) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        if (bus.mem_wr_en === 1'b1) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_en) begin
            if (bus.mem_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
            if (bus.mem_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
            if (bus.ls_rvalid === 1'b1) rv_cnt <= rv_cnt + 1;
        end
    end

    // Scoreboard monitor and always-on output invariants.
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (mon_en) begin
            check("rw_excl", {31'b0, bus.mem_rd_en & bus.mem_wr_en}, 32'd0);
            if (!bus.mem_rd_en && !bus.mem_wr_en) begin
                check("addr_idle", bus.mem_addr, 32'd0);
                check("wdata_idle", bus.mem_wdata, 32'd0);
            end
            if (!bus.ls_rvalid) begin
                check("ls_rdata_idle", bus.ls_rdata, 32'd0);
                check("ls_err_idle", {31'b0, bus.ls_err}, 32'd0);
            end else begin
                check("ls_pending", {31'b0, ls_q.size() != 0}, 32'd1);
                if (ls_q.size() != 0) begin
                    e = ls_q.pop_front();
                    check("ls_rdata", bus.ls_rdata, e.data);
                    check("ls_err", {31'b0, bus.ls_err}, {31'b0, e.err});
                    check("ls_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (!bus.if_rvalid) begin
                check("if_rdata_idle", bus.if_rdata, 32'd0);
            end else begin
                check("if_pending", {31'b0, if_q.size() != 0}, 32'd1);
                if (if_q.size() != 0) begin
                    e = if_q.pop_front();
                    check("if_rdata", bus.if_rdata, e.data);
                    check("if_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (bus.mem_wr_en) begin
                check("wr_pending", {31'b0, wr_q.size() != 0}, 32'd1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    check("wr_addr", bus.mem_addr, w.addr);
                    check("wr_data", bus.mem_wdata, w.data);
                    check("wr_cycle", 32'(cyc), 32'(w.due));
                end
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((ls_q.size() + if_q.size() + wr_q.size()) != 0 && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        check("drain", 32'(ls_q.size() + if_q.size() + wr_q.size()), 32'd0);
    endtask

    task automatic ls_issue(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd, input bit push,
                            input logic [31:0] want_data, input logic want_err,
                            input int lat, output int t);
        rsp_t e;
        @(posedge clk); #1;
        bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_size = sz;
        bus.ls_unsigned = uns; bus.ls_addr = a; bus.ls_wdata = wd;
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ls_gnt === 1'b1) begin
                t = cyc;
                break;
            end
        end
        check("ls_gnt_seen", {31'b0, t >= 0}, 32'd1);
        if (push && t >= 0) begin
            e.data = want_data; e.err = want_err; e.due = t + lat;
            ls_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.ls_req = 1'b0;
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] want);
        int t;
        ls_issue(1'b0, sz, uns, a, 32'd0, 1'b1, want, 1'b0, 3, t);
        @(negedge clk);
        check("rd_issue_en", {31'b0, bus.mem_rd_en}, 32'd1);
        check("rd_issue_addr", bus.mem_addr, {a[31:2], 2'b00});
        drain();
    endtask

    task automatic store_rmw(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] want_word);
        int  t;
        wr_t w;
        ls_issue(1'b1, sz, 1'b0, a, wd, 1'b1, 32'd0, 1'b0, 4, t);
        w.addr = {a[31:2], 2'b00}; w.data = want_word; w.due = t + 3;
        wr_q.push_back(w);
        @(negedge clk);
        check("rmw_rd_en", {31'b0, bus.mem_rd_en}, 32'd1);
        drain();
    endtask

    task automatic store_word(input logic [31:0] a, input logic [31:0] wd);
        int  t;
        wr_t w;
        ls_issue(1'b1, 2'b10, 1'b0, a, wd, 1'b1, 32'd0, 1'b0, 2, t);
        w.addr = a; w.data = wd; w.due = t + 1;
        wr_q.push_back(w);
        drain();
    endtask

    task automatic misaligned(input logic we, input logic [1:0] sz, input logic [31:0] a);
        int t;
        int s;
        s = rd_cnt + wr_cnt;
        ls_issue(we, sz, 1'b0, a, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 1, t);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("misal_no_strobe", 32'(rd_cnt + wr_cnt), 32'(s));
    endtask

    initial begin
        int t;
        int n;
        int w_snap;
        int v_snap;
        rsp_t e;

        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b10;
        bus.ls_unsigned = 1'b0; bus.ls_addr = 32'h0000_0100; bus.ls_wdata = 32'd0;

        // Reset hold with both requesters asking.
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
            check("rst_ls_gnt", {31'b0, bus.ls_gnt}, 32'd0);
            check("rst_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
            check("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
            check("rst_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
            check("rst_wr_en", {31'b0, bus.mem_wr_en}, 32'd0);
            @(posedge clk); #1;
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        preload(32'h100, 32'h80FF_0000);
        preload(32'h200, 32'h1122_3344);
        preload(32'h300, 32'hCAFE_F00D);
        check("rst_no_strobes", 32'(rd_cnt + wr_cnt), 32'd0);
        rst = 1'b1;

        // Loads: lane extraction with sign/zero extension.
        load(2'b00, 1'b0, 32'h103, 32'hFFFF_FF80);
        load(2'b00, 1'b1, 32'h103, 32'h0000_0080);
        load(2'b01, 1'b0, 32'h102, 32'hFFFF_80FF);
        load(2'b01, 1'b1, 32'h102, 32'h0000_80FF);
        load(2'b01, 1'b0, 32'h100, 32'h0000_0000);
        load(2'b00, 1'b0, 32'h102, 32'hFFFF_FFFF);
        load(2'b10, 1'b0, 32'h100, 32'h80FF_0000);
        load(2'b01, 1'b0, 32'h300, 32'hFFFF_F00D);
        load(2'b00, 1'b1, 32'h301, 32'h0000_00F0);
        load(2'b00, 1'b0, 32'h301, 32'hFFFF_FFF0);
        load(2'b01, 1'b1, 32'h302, 32'h0000_CAFE);

        // Sub-word stores (read-modify-write) and word stores.
        store_rmw(2'b00, 32'h201, 32'h0000_00AB, 32'h1122_AB44);
        preload(32'h200, 32'h1122_3344);
        store_rmw(2'b01, 32'h202, 32'h0000_BEEF, 32'hBEEF_3344);
        load(2'b10, 1'b0, 32'h200, 32'hBEEF_3344);
        store_word(32'h204, 32'hDEAD_BEEF);
        store_rmw(2'b00, 32'h207, 32'hFFFF_FF12, 32'h12AD_BEEF);
        store_rmw(2'b01, 32'h204, 32'hAAAA_5678, 32'h12AD_5678);
        load(2'b10, 1'b0, 32'h204, 32'h12AD_5678);

        // Misaligned and illegal accesses.
        misaligned(1'b0, 2'b10, 32'h102);
        misaligned(1'b0, 2'b01, 32'h101);
        misaligned(1'b0, 2'b11, 32'h100);
        misaligned(1'b1, 2'b01, 32'h203);
        misaligned(1'b1, 2'b10, 32'h201);

        // Lone fetch; address low bits ignored.
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0103;
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.if_gnt === 1'b1) begin
                t = cyc;
                break;
            end
        end
        check("if_gnt_seen", {31'b0, t >= 0}, 32'd1);
        e.data = 32'h80FF_0000; e.err = 1'b0; e.due = t + 3;
        if_q.push_back(e);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        @(negedge clk);
        check("if_rd_en", {31'b0, bus.mem_rd_en}, 32'd1);
        check("if_rd_addr", bus.mem_addr, 32'h0000_0100);
        drain();

        // Starvation: both requests held; fetch wins every fifth arbitration.
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0300;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h0000_0100;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge clk);
            if (bus.ls_gnt || bus.if_gnt) begin
                check("gnt_excl", {31'b0, bus.ls_gnt & bus.if_gnt}, 32'd0);
                check("starve_pick", {31'b0, bus.if_gnt}, {31'b0, (n % 5) == 4});
                e.err = 1'b0; e.due = cyc + 3;
                if (bus.if_gnt) begin
                    e.data = 32'hCAFE_F00D;
                    if_q.push_back(e);
                end else begin
                    e.data = 32'h80FF_0000;
                    ls_q.push_back(e);
                end
                n++;
            end
        end
        check("starve_grants", 32'(n), 32'd10);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        drain();

        // Reset in the middle of a read-modify-write.
        ls_issue(1'b1, 2'b00, 1'b0, 32'h200, 32'h0000_0055, 1'b0, 32'd0, 1'b0, 4, t);
        @(negedge clk);
        check("abort_rd_en", {31'b0, bus.mem_rd_en}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        w_snap = wr_cnt;
        v_snap = rv_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_write", 32'(wr_cnt), 32'(w_snap));
        check("abort_no_rvalid", 32'(rv_cnt), 32'(v_snap));
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h0000_0200;
        @(negedge clk);
        check("idle_after_rst", {31'b0, bus.ls_gnt}, 32'd1);
        e.data = 32'hBEEF_3344; e.err = 1'b0; e.due = cyc + 3;
        if (bus.ls_gnt === 1'b1) ls_q.push_back(e);
        @(posedge clk); #1;
        bus.ls_req = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
